// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_channel
// Brief    : NUM_CH-channel PWM generator. Programmable period (TOP),
//            clock prescaler (DIV), and per-channel duty registers.
//            Duty and TOP are double-buffered and load at period wrap.
//            DIV has no shadow register.
//            Optional macro PWM_CENTER_ALIGN_EN selects up/down
//            (centre-aligned) counting.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi_channel #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8,
    parameter int DIV_W  = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         wr_en,
    input  logic [7:0]                                   wr_addr,
    input  logic [((CNT_W > DIV_W) ? CNT_W : DIV_W)-1:0] wr_data,
    input  logic [NUM_CH-1:0]                            out_en,
    input  logic [NUM_CH-1:0]                            pwm_en,
    output logic [NUM_CH-1:0]                            pwm_out,
    output logic                                         period_tick
);

    localparam logic [7:0] c_addr_top = 8'h80;
    localparam logic [7:0] c_addr_div = 8'h81;

    logic [CNT_W-1:0]  r_top_pend;
    logic [CNT_W-1:0]  r_top_act;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_pre_cnt;
    logic              w_tick;
    logic              w_wrap;
    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] r_pwm_out;
    logic              r_period_tick;

    assign w_tick = (r_pre_cnt == r_div);

    // TOP (shadowed) and DIV (immediate) register writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_top_pend <= '1;
            r_div      <= '0;
        end else if (wr_en) begin
            if (wr_addr == c_addr_top) r_top_pend <= wr_data[CNT_W-1:0];
            if (wr_addr == c_addr_div) r_div      <= wr_data[DIV_W-1:0];
        end
    end

    // Active TOP loads from pending only at a period wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_top_act <= '1;
        end else if (w_wrap) begin
            r_top_act <= r_top_pend;
        end
    end

    // Prescaler: counts 0..DIV, wraps naturally if DIV drops below it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + DIV_W'(1);
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    logic r_dir;
    logic w_dir_nxt;

    // Up/down counter next state; wrap when reaching 0 on the way down
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        w_wrap    = 1'b0;
        if (w_tick) begin
            if (r_top_act == '0) begin
                // TOP=0 degenerates to edge-aligned: every tick is a wrap
                w_cnt_nxt = '0;
                w_dir_nxt = 1'b0;
                w_wrap    = 1'b1;
            end else if (!r_dir) begin
                if (r_cnt == r_top_act) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    w_dir_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end else begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt = '0;
                    w_dir_nxt = 1'b0;
                    w_wrap    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
        end
    end

    // Count direction register (0 = up, 1 = down)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir <= 1'b0;
        end else begin
            r_dir <= w_dir_nxt;
        end
    end
`else
    // Edge-aligned counter next state: 0..TOP then wrap
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_wrap    = 1'b0;
        if (w_tick) begin
            if (r_cnt == r_top_act) begin
                w_cnt_nxt = '0;
                w_wrap    = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end
`endif

    // Main period counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Per-channel duty registers (pending + active) and compare level
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CNT_W-1:0] r_duty_pend;
            logic [CNT_W-1:0] r_duty_act;

            // Pending duty written from the register path
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_duty_pend <= '0;
                end else if (wr_en && (wr_addr == 8'(i))) begin
                    r_duty_pend <= wr_data[CNT_W-1:0];
                end
            end

            // Active duty loads from pending only at a period wrap
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_duty_act <= '0;
                end else if (w_wrap) begin
                    r_duty_act <= r_duty_pend;
                end
            end

            assign w_level[i] = (r_cnt < r_duty_act);
        end
    endgenerate

    // Registered output mux and period pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_out     <= '0;
            r_period_tick <= 1'b0;
        end else begin
            r_pwm_out     <= out_en & (~pwm_en | w_level);
            r_period_tick <= w_wrap;
        end
    end

    assign pwm_out     = r_pwm_out;
    assign period_tick = r_period_tick;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi_channel
// Brief    : Directed self-checking bench for pwm_multi_channel (defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_channel;

    localparam int NUM_CH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [7:0]        wr_addr;
    logic [7:0]        wr_data;
    logic [NUM_CH-1:0] out_en;
    logic [NUM_CH-1:0] pwm_en;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_tick;

    int                n_chk  = 0;
    int                n_pass = 0;
    int                hi [NUM_CH];
    int                ticks;
    logic [NUM_CH-1:0] seen_out;
    int                cyc;
    int                other;

    pwm_multi_channel #(
        .NUM_CH (NUM_CH),
        .CNT_W  (8),
        .DIV_W  (8)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .out_en      (out_en),
        .pwm_en      (pwm_en),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    // One register write; starts and ends on a falling edge
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Cycles until the next period_tick, collecting any high output seen
    task automatic cycles_to_tick(input int limit, output int n);
        n        = 0;
        seen_out = '0;
        do begin
            @(negedge clk);
            n++;
            seen_out |= pwm_out;
        end while (!period_tick && n < limit);
        chk("tick_seen", {31'd0, period_tick}, 1);
    endtask

    // Per-channel high-cycle counts and tick count over n cycles
    task automatic count_window(input int n);
        for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
        ticks = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) hi[i] += int'(pwm_out[i]);
            ticks += int'(period_tick);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        out_en = '0; pwm_en = '0;
        repeat (3) @(negedge clk);

        // 1: reset state, all duty 0, default period 256
        chk("rst_pwm_out", pwm_out, 0);
        chk("rst_tick", {31'd0, period_tick}, 0);
        out_en = '1; pwm_en = '1; rst = 1'b0;
        cycles_to_tick(300, cyc);
        chk("t1_first_period", cyc, 256);
        chk("t1_out_low", seen_out, 0);
        cycles_to_tick(300, cyc);
        chk("t1_period", cyc, 256);

        // 2: duty0=0x80, duty1=0xFF with TOP=0xFF
        wr(8'h00, 8'h80);
        wr(8'h01, 8'hFF);
        cycles_to_tick(300, cyc);
        cycles_to_tick(300, cyc);
        chk("t2_period", cyc, 256);
        count_window(256);
        chk("t2_ch0_hi", hi[0], 128);
        chk("t2_ch1_hi", hi[1], 255);
        other = 0;
        for (int i = 2; i < NUM_CH; i++) other += hi[i];
        chk("t2_others_hi", other, 0);
        chk("t2_ticks", ticks, 1);

        // 3: TOP=9, duty3=5 written just after a wrap; old period finishes
        cycles_to_tick(300, cyc);
        wr(8'h80, 8'd9);
        wr(8'h03, 8'd5);
        cycles_to_tick(300, cyc);
        chk("t3_old_period", cyc + 2, 256);
        cycles_to_tick(30, cyc);
        chk("t3_new_period", cyc, 10);
        count_window(10);
        chk("t3_ch3_hi", hi[3], 5);
        chk("t3_ch0_full", hi[0], 10);
        chk("t3_ch2_lo", hi[2], 0);

        // 4: DIV=3, TOP=4, duty2=2 -> period 20, ch2 high 8
        wr(8'h81, 8'd3);
        wr(8'h80, 8'd4);
        wr(8'h02, 8'd2);
        cycles_to_tick(100, cyc);
        cycles_to_tick(100, cyc);
        chk("t4_period", cyc, 20);
        count_window(20);
        chk("t4_ch2_hi", hi[2], 8);
        chk("t4_ch3_full", hi[3], 20);
        chk("t4_ticks", ticks, 1);

        // 5: static-high mode, output disable, unmapped writes
        chk("t5_ch5_pwm_lo", {31'd0, pwm_out[5]}, 0);
        pwm_en[5] = 1'b0;
        @(negedge clk);
        chk("t5_ch5_static", {31'd0, pwm_out[5]}, 1);
        count_window(20);
        chk("t5_ch5_const", hi[5], 20);
        out_en[5] = 1'b0;
        @(negedge clk);
        chk("t5_ch5_off", {31'd0, pwm_out[5]}, 0);
        wr(8'h90, 8'd0);
        wr(8'h10, 8'd0);
        wr(8'hC1, 8'd0);
        out_en[5] = 1'b1; pwm_en[5] = 1'b1;
        cycles_to_tick(100, cyc);
        cycles_to_tick(100, cyc);
        chk("t5_period_kept", cyc, 20);
        count_window(20);
        chk("t5_ch0_kept", hi[0], 20);
        chk("t5_ch2_kept", hi[2], 8);

        // 6: reset mid-period
        wr(8'h00, 8'h40);
        cycles_to_tick(100, cyc);
        cycles_to_tick(100, cyc);
        chk("t6_ch0_hi", {31'd0, pwm_out[0]}, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_out", pwm_out, 0);
        chk("t6_rst_tick", {31'd0, period_tick}, 0);
        rst = 1'b0;
        cycles_to_tick(300, cyc);
        chk("t6_period_after_rst", cyc, 256);
        chk("t6_out_low", seen_out, 0);

        // 7: TOP=0 -> wrap every tick; duty 0 low, duty>=1 high
        wr(8'h80, 8'd0);
        wr(8'h01, 8'd1);
        cycles_to_tick(300, cyc);
        cycles_to_tick(5, cyc);
        chk("t7_period", cyc, 1);
        count_window(8);
        chk("t7_ch1_hi", hi[1], 8);
        chk("t7_ch0_lo", hi[0], 0);
        chk("t7_ticks", ticks, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
